data_mem_resp: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/data_mem_resp_mem_array.sv | 22 ++
 rtl/data_mem_resp.sv | 105 ++++++++++
 tb/tb_data_mem_resp.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU:
// opcodes, memory-op encoding and the data-memory FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_STORE = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_NAND  = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_XNOR  = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_RD,
    MEM_WR
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/data_mem_resp_mem_array.sv
// Single-port word RAM: clocked write, read port follows addr.
// No reset; contents survive a CPU reset.
module mem_array #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one request at a time, waits
// WAIT_CYC cycles, performs the access, then pulses ready.
module data_mem_resp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              mReadFlag,
  input  logic              mWriteFlag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  mem_state_e        state_q;
  mem_op_e           op_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic              access;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  // Gate with rst so a reset coinciding with the access edge drops the write
  assign mem_we = access && (op_q == MEM_WR) && !rst;

  mem_array #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q),
    .din  (wdata_q),
    .dout (mem_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MEM_NONE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req && mReadFlag && mWriteFlag) begin
            err_q <= 1'b1;
          end else if (req && (mReadFlag ^ mWriteFlag)) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= mReadFlag ? MEM_RD : MEM_WR;
            cnt_q   <= WAIT_INIT;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (op_q == MEM_RD) rdata_q <= mem_dout;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          op_q    <= MEM_NONE;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance
// share stimulus; each phase checks only the instance it targets.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;

  logic [15:0] rdata2, rdata0;
  logic        ready2, ready0;
  logic        busy2, busy0;
  logic        err2, err0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(2)) u2 (
    .clk(clk), .rst(rst), .req(req), .mReadFlag(rd), .mWriteFlag(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2),
    .busy(busy2), .err(err2)
  );

  data_mem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(0)) u0 (
    .clk(clk), .rst(rst), .req(req), .mReadFlag(rd), .mWriteFlag(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0),
    .busy(busy0), .err(err0)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access; s0 selects the zero-wait instance for checking.
  // intr drives a stray write to 0x05 while the access is in WAIT.
  task automatic acc(input bit s0, input bit r, input bit w,
                     input logic [7:0] a, input logic [15:0] d,
                     input bit intr, input string tag);
    int lat;
    lat = s0 ? 1 : 3;
    @(negedge clk);
    req = 1'b1; rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    if (intr) begin
      req = 1'b1; rd = 1'b0; wr = 1'b1; addr = 8'h05; wdata = 16'hBEEF;
    end else begin
      req = 1'b0; rd = 1'b0; wr = 1'b0;
    end
    chk({tag, "_busy_acc"}, 16'(s0 ? busy0 : busy2), 16'd1);
    chk({tag, "_rdy_acc"}, 16'(s0 ? ready0 : ready2), 16'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      req = 1'b0; rd = 1'b0; wr = 1'b0;
      chk({tag, "_rdy_wait"}, 16'(ready2), 16'd0);
    end
    @(negedge clk);
    req = 1'b0; rd = 1'b0; wr = 1'b0;
    chk({tag, "_rdy"}, 16'(s0 ? ready0 : ready2), 16'd1);
    chk({tag, "_busy_done"}, 16'(s0 ? busy0 : busy2), 16'd1);
    @(negedge clk);
    chk({tag, "_rdy_end"}, 16'(s0 ? ready0 : ready2), 16'd0);
    chk({tag, "_busy_end"}, 16'(s0 ? busy0 : busy2), 16'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_rdata2", rdata2, 16'h0000);
    chk("rst_ready2", 16'(ready2), 16'd0);
    chk("rst_busy2", 16'(busy2), 16'd0);
    chk("rst_err2", 16'(err2), 16'd0);
    chk("rst_rdata0", rdata0, 16'h0000);
    chk("rst_busy0", 16'(busy0), 16'd0);
    rst = 1'b0;

    // Write then read, two wait states
    acc(1'b0, 1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, "wr05");
    chk("wr_keeps_rdata", rdata2, 16'h0000);
    acc(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, "rd05");
    chk("rd05_data", rdata2, 16'h1234);

    // Illegal request: both flags
    @(negedge clk);
    req = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'h05; wdata = 16'hDEAD;
    @(negedge clk);
    req = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("ill_err", 16'(err2), 16'd1);
    chk("ill_busy", 16'(busy2), 16'd0);
    chk("ill_err0", 16'(err0), 16'd1);
    @(negedge clk);
    chk("ill_err_clr", 16'(err2), 16'd0);
    chk("ill_ready", 16'(ready2), 16'd0);
    acc(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, "rd05b");
    chk("ill_rd05", rdata2, 16'h1234);

    // Request while busy is ignored
    acc(1'b0, 1'b0, 1'b1, 8'h07, 16'h0777, 1'b0, "wr07");
    acc(1'b0, 1'b1, 1'b0, 8'h07, 16'h0000, 1'b1, "rd07");
    chk("rd07_data", rdata2, 16'h0777);
    acc(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, "rd05c");
    chk("busy_ign_05", rdata2, 16'h1234);

    // Reset in WAIT drops the write
    acc(1'b0, 1'b0, 1'b1, 8'h09, 16'h0001, 1'b0, "wr09");
    @(negedge clk);
    req = 1'b1; rd = 1'b0; wr = 1'b1; addr = 8'h09; wdata = 16'h5555;
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
    chk("rstw_busy", 16'(busy2), 16'd1);
    rst = 1'b1;
    #1;
    chk("rstw_busy_clr", 16'(busy2), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_no_ready", 16'(ready2), 16'd0);
    end
    acc(1'b0, 1'b1, 1'b0, 8'h09, 16'h0000, 1'b0, "rd09");
    chk("rstw_rd09", rdata2, 16'h0001);

    // Zero wait states at address extremes
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc(1'b1, 1'b0, 1'b1, 8'h00, 16'hA5A5, 1'b0, "z_wr00");
    acc(1'b1, 1'b0, 1'b1, 8'hFF, 16'h5A5A, 1'b0, "z_wrFF");
    chk("z_rdata_hold", rdata0, 16'h0000);
    acc(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, "z_rd00");
    chk("z_rd00_data", rdata0, 16'hA5A5);
    acc(1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, "z_rdFF");
    chk("z_rdFF_data", rdata0, 16'h5A5A);
    acc(1'b1, 1'b0, 1'b1, 8'h00, 16'h1111, 1'b0, "z_wr00b");
    chk("z_wr_no_disturb", rdata0, 16'h5A5A);
    acc(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, "z_rd00b");
    chk("z_rd00b_data", rdata0, 16'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
